backtrack_ctrl: RTL and testbench
=================================

// Module: backtrack_ctrl
// PURPOSE
//  Consumer/reader side of the trace-table stack. On a conflict, pops trace entries,
//  unassigning each variable, until the most recent Decide entry is found; it then pushes
//  that variable back as Forced with the opposite value. An empty trace means UNSAT.
//  Sits between the conflict detector, the trace-table stack and the variable-state store.
// PARAMETERS
//  VAR_BITS   `MAX_VARS_BITS  width of a variable index
//  CNT_BITS   16              width of bt_count (only with BT_STATS_EN)
// PORTS
//  clock        in   1         system clock
//  reset        in   1         synchronous, active-high
//  bt_start     in   1         conflict detected; request one backtrack
//  bt_busy      out  1         FSM not in IDLE
//  bt_done      out  1         1-cycle pulse: flip pushed
//  bt_unsat     out  1         1-cycle pulse: trace empty, no decision left
//  flip_var     out  VAR_BITS  flipped variable (valid with bt_done)
//  flip_val     out  1         new value of flip_var (valid with bt_done)
//  tt_pop       out  1         pop request to trace stack
//  tt_push      out  1         push request to trace stack
//  tt_type_wr   out  1         pushed type (always 1 = Forced)
//  tt_val_wr    out  1         pushed value
//  tt_var_wr    out  VAR_BITS  pushed variable
//  tt_type_rd   in   1         popped type (0 Decide, 1 Forced); combinational with tt_pop
//  tt_val_rd    in   1         popped value
//  tt_var_rd    in   VAR_BITS  popped variable
//  tt_empty     in   1         trace stack empty (registered in stack)
//  unassign_en  out  1         clear assignment of unassign_var this cycle
//  unassign_var out  VAR_BITS  variable to unassign
//  assign_en    out  1         write flip_val to flip_var this cycle
//  bt_count     out  CNT_BITS  completed backtracks (only with BT_STATS_EN)
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; latched var/val regs 0. Reset wins over all inputs;
//    reset mid-backtrack aborts: next cycle IDLE, no push, no done/unsat pulse.
//  - States IDLE, POP, PUSH. All outputs decoded from state + inputs; no extra latency.
//  - IDLE: bt_busy=0. bt_start=1 -> POP. bt_start while busy is ignored (not queued).
//  - POP, tt_empty=0: tt_pop=1; same cycle unassign_en=1, unassign_var=tt_var_rd.
//    tt_type_rd=1 -> stay POP. tt_type_rd=0 -> latch var=tt_var_rd, val=~tt_val_rd; -> PUSH.
//  - POP, tt_empty=1: tt_pop=0, bt_unsat=1 for this cycle, -> IDLE. No push.
//  - PUSH: tt_push=1, tt_type_wr=1, tt_val_wr=latched val, tt_var_wr=latched var;
//    assign_en=1; bt_done=1; flip_var/flip_val=latched values; -> IDLE.
//    Stack cannot be full here (one entry just popped); tt_pop never asserted with tt_push.
//  - Latency: bt_start at edge t; N pops occupy cycles t+1..t+N; done at cycle t+N+1.
//    Empty trace at start: unsat at cycle t+1.
//  - flip_var/flip_val read 0 outside PUSH. bt_busy=1 in POP and PUSH.
//  - Relies on the stack updating pointer and empty flag at the pop edge, so back-to-back
//    pops in consecutive cycles read successive entries.
// CONFIGURATION
//  - BT_STATS_EN defined: bt_count port present; +1 on every bt_done, saturates at
//    all-ones; unchanged on unsat; reset to 0.
//  - BT_STATS_EN undefined: bt_count port and counter absent; all else identical.
// TESTING
//  1 Reset with bt_start=1 -> all outputs 0, IDLE; after release bt_busy=0.
//  2 Trace bottom->top D(v3,1),F(v5,0),F(v7,1); bt_start -> unassign 7,5,3 in cycles
//    t+1..t+3; cycle t+4 push {type1,val0,var3}, bt_done=1, flip_var=3, flip_val=0.
//  3 Top entry D(v2,0) -> one pop, unassign 2; cycle t+2 push F(v2,1), bt_done=1.
//  4 Trace F(v1,1),F(v4,0) only -> unassign 4 then 1; cycle t+3 bt_unsat=1, no push, empty=1.
//  5 bt_start pulsed again during POP -> ignored; reset asserted in a POP cycle ->
//    next cycle IDLE, no tt_push, no bt_done.
//  6 BT_STATS_EN, CNT_BITS=2: four successful backtracks -> bt_count 1,2,3,3; unsat leaves it.

Source files
------------

// File: rtl/backtrack_ctrl_if.sv
// -----------------------------------------------------------------------------
// backtrack_ctrl_if
//   Bus between the backtrack controller and the trace-table stack.
//   master : the backtrack controller (issues pop/push, reads the popped entry)
//   slave  : the trace-table stack
//   Signals:
//     tt_pop      pop request            (master -> slave)
//     tt_push     push request           (master -> slave)
//     tt_type_wr  pushed type, 1=Forced  (master -> slave)
//     tt_val_wr   pushed value           (master -> slave)
//     tt_var_wr   pushed variable        (master -> slave)
//     tt_type_rd  top entry type, 0=Decide 1=Forced (slave -> master)
//     tt_val_rd   top entry value        (slave -> master)
//     tt_var_rd   top entry variable     (slave -> master)
//     tt_empty    stack empty, registered in the stack (slave -> master)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

interface backtrack_ctrl_if #(
  parameter int VAR_BITS = `MAX_VARS_BITS
) ();
  logic                tt_pop;
  logic                tt_push;
  logic                tt_type_wr;
  logic                tt_val_wr;
  logic [VAR_BITS-1:0] tt_var_wr;
  logic                tt_type_rd;
  logic                tt_val_rd;
  logic [VAR_BITS-1:0] tt_var_rd;
  logic                tt_empty;

  modport master (
    output tt_pop, tt_push, tt_type_wr, tt_val_wr, tt_var_wr,
    input  tt_type_rd, tt_val_rd, tt_var_rd, tt_empty
  );

  modport slave (
    input  tt_pop, tt_push, tt_type_wr, tt_val_wr, tt_var_wr,
    output tt_type_rd, tt_val_rd, tt_var_rd, tt_empty
  );
endinterface

// File: rtl/backtrack_ctrl.sv
// -----------------------------------------------------------------------------
// backtrack_ctrl
//   Reader side of the trace-table stack. On a conflict it pops trace entries,
//   unassigning each popped variable, until the most recent Decide entry is
//   found; that variable is then pushed back as Forced with the opposite value
//   and written to the variable store. Running out of entries reports UNSAT.
//
//   Optional feature macro: BT_STATS_EN
//     defined   -> CNT_BITS parameter and bt_count port present; bt_count
//                  counts completed backtracks, saturating at all-ones.
//     undefined -> no counter, no bt_count port.
//
//   Ports:
//     clock         system clock
//     reset         synchronous, active-high
//     bt_start      conflict detected; request one backtrack (ignored if busy)
//     bt_busy       controller is not idle
//     bt_done       1-cycle pulse: flipped decision pushed
//     bt_unsat      1-cycle pulse: trace empty, no decision left
//     flip_var      flipped variable (valid with bt_done, else 0)
//     flip_val      new value of flip_var (valid with bt_done, else 0)
//     tt            trace-stack bus (master side)
//     unassign_en   clear assignment of unassign_var this cycle
//     unassign_var  variable to unassign
//     assign_en     write flip_val to flip_var this cycle
//     bt_count      completed backtracks (BT_STATS_EN only)
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | waiting for bt_start
// POP    | popping trace entries until a Decide entry or an empty stack
// PUSH   | pushing the flipped decision back as Forced, reporting done
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module backtrack_ctrl #(
  parameter int VAR_BITS = `MAX_VARS_BITS
`ifdef BT_STATS_EN
  ,
  parameter int CNT_BITS = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bt_start,
  output logic                bt_busy,
  output logic                bt_done,
  output logic                bt_unsat,
  output logic [VAR_BITS-1:0] flip_var,
  output logic                flip_val,
  backtrack_ctrl_if.master    tt,
  output logic                unassign_en,
  output logic [VAR_BITS-1:0] unassign_var,
  output logic                assign_en
`ifdef BT_STATS_EN
  ,
  output logic [CNT_BITS-1:0] bt_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [VAR_BITS-1:0] var_q;
  logic                val_q;

  logic                pop_c;
  logic                push_c;
  logic                type_wr_c;
  logic                val_wr_c;
  logic [VAR_BITS-1:0] var_wr_c;

  // A Decide entry seen while popping ends the pop phase.
  logic                decide_hit;
  assign decide_hit = (state == S_POP) && !tt.tt_empty && !tt.tt_type_rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      var_q <= '0;
      val_q <= 1'b0;
    end else if (decide_hit) begin
      var_q <= tt.tt_var_rd;
      val_q <= ~tt.tt_val_rd;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bt_start) state_nxt = S_POP;
      end
      S_POP: begin
        if (tt.tt_empty)         state_nxt = S_IDLE;
        else if (!tt.tt_type_rd) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so that a reset arriving in
  // the middle of a backtrack cannot issue a pop or push in that cycle.
  always_comb begin
    bt_busy      = 1'b0;
    bt_done      = 1'b0;
    bt_unsat     = 1'b0;
    flip_var     = '0;
    flip_val     = 1'b0;
    unassign_en  = 1'b0;
    unassign_var = '0;
    assign_en    = 1'b0;
    pop_c        = 1'b0;
    push_c       = 1'b0;
    type_wr_c    = 1'b0;
    val_wr_c     = 1'b0;
    var_wr_c     = '0;
    if (!reset) begin
      case (state)
        S_POP: begin
          bt_busy = 1'b1;
          if (tt.tt_empty) begin
            bt_unsat = 1'b1;
          end else begin
            pop_c        = 1'b1;
            unassign_en  = 1'b1;
            unassign_var = tt.tt_var_rd;
          end
        end
        S_PUSH: begin
          bt_busy   = 1'b1;
          push_c    = 1'b1;
          type_wr_c = 1'b1;
          val_wr_c  = val_q;
          var_wr_c  = var_q;
          assign_en = 1'b1;
          bt_done   = 1'b1;
          flip_var  = var_q;
          flip_val  = val_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign tt.tt_pop     = pop_c;
  assign tt.tt_push    = push_c;
  assign tt.tt_type_wr = type_wr_c;
  assign tt.tt_val_wr  = val_wr_c;
  assign tt.tt_var_wr  = var_wr_c;

`ifdef BT_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      bt_count <= '0;
    end else if (bt_done && (bt_count != {CNT_BITS{1'b1}})) begin
      bt_count <= bt_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_backtrack_ctrl.sv
`timescale 1ns/1ps

module tb_backtrack_ctrl;
  localparam int VB = 6;
`ifdef BT_STATS_EN
  localparam int CW = 2;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          bt_start;
  logic          bt_busy, bt_done, bt_unsat, flip_val, unassign_en, assign_en;
  logic [VB-1:0] flip_var, unassign_var;
`ifdef BT_STATS_EN
  logic [CW-1:0] bt_count;
`endif

  backtrack_ctrl_if #(.VAR_BITS(VB)) tt ();

  backtrack_ctrl #(
    .VAR_BITS(VB)
`ifdef BT_STATS_EN
    , .CNT_BITS(CW)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bt_start     (bt_start),
    .bt_busy      (bt_busy),
    .bt_done      (bt_done),
    .bt_unsat     (bt_unsat),
    .flip_var     (flip_var),
    .flip_val     (flip_val),
    .tt           (tt),
    .unassign_en  (unassign_en),
    .unassign_var (unassign_var),
    .assign_en    (assign_en)
`ifdef BT_STATS_EN
    , .bt_count   (bt_count)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- trace stack model (slave side) ----------------
  logic          st_type [16];
  logic          st_val  [16];
  logic [VB-1:0] st_var  [16];
  int            sp;
  logic          tb_clear, tb_push, tb_push_type, tb_push_val;
  logic [VB-1:0] tb_push_var;

  always @(posedge clock) begin
    if (tb_clear) begin
      sp <= 0;
    end else if (tb_push) begin
      st_type[sp] <= tb_push_type;
      st_val[sp]  <= tb_push_val;
      st_var[sp]  <= tb_push_var;
      sp <= sp + 1;
    end else if (tt.tt_pop && sp > 0) begin
      sp <= sp - 1;
    end else if (tt.tt_push && sp < 16) begin
      st_type[sp] <= tt.tt_type_wr;
      st_val[sp]  <= tt.tt_val_wr;
      st_var[sp]  <= tt.tt_var_wr;
      sp <= sp + 1;
    end
  end

  always_comb begin
    tt.tt_empty   = (sp == 0);
    tt.tt_type_rd = 1'b0;
    tt.tt_val_rd  = 1'b0;
    tt.tt_var_rd  = '0;
    if (sp > 0 && sp <= 16) begin
      tt.tt_type_rd = st_type[sp-1];
      tt.tt_val_rd  = st_val[sp-1];
      tt.tt_var_rd  = st_var[sp-1];
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit      t;
    bit      v;
    int      var_;
  } ent_t;

  typedef struct {
    int      depth;
    bit [3:0] typ;
    bit [3:0] val;
    int      vars [4];
    int      n_pops;
    bit      done;
    int      fvar;
    bit      fval;
  } vec_t;

  ent_t load_q [$];
  int   exp_pops [$];
  bit   exp_done;
  int   exp_var;
  bit   exp_val;
  int   exp_cnt;

  // Reference: scan the trace from the top; every entry down to and including
  // the newest Decide is unassigned; that Decide comes back flipped. No Decide
  // at all means every entry is unassigned and the result is UNSAT.
  task automatic model_bt();
    exp_pops.delete();
    exp_done = 0; exp_var = 0; exp_val = 0;
    for (int i = load_q.size() - 1; i >= 0; i--) begin
      exp_pops.push_back(load_q[i].var_);
      if (!load_q[i].t) begin
        exp_done = 1;
        exp_var  = load_q[i].var_;
        exp_val  = !load_q[i].v;
        break;
      end
    end
  endtask

  task automatic clear_stack();
    @(negedge clock); tb_clear = 1;
    @(negedge clock); tb_clear = 0;
    load_q.delete();
  endtask

  task automatic push_entry(input bit t, input bit v, input int var_);
    ent_t e;
    @(negedge clock);
    tb_push = 1; tb_push_type = t; tb_push_val = v; tb_push_var = var_[VB-1:0];
    @(negedge clock);
    tb_push = 0;
    e.t = t; e.v = v; e.var_ = var_;
    load_q.push_back(e);
  endtask

  task automatic run_bt(input string tag, input bit hold);
    int n;
    int dep;
    n   = exp_pops.size();
    dep = load_q.size();
    @(negedge clock); bt_start = 1;
    @(negedge clock); if (!hold) bt_start = 0;
    for (int i = 0; i < n; i++) begin
      chk({tag, " pop.busy"},   32'(bt_busy), 1);
      chk({tag, " pop.tt_pop"}, 32'(tt.tt_pop), 1);
      chk({tag, " pop.un_en"},  32'(unassign_en), 1);
      chk({tag, " pop.un_var"}, 32'(unassign_var), exp_pops[i]);
      chk({tag, " pop.push"},   32'(tt.tt_push), 0);
      chk({tag, " pop.done"},   32'(bt_done), 0);
      @(negedge clock);
    end
    bt_start = 0;
    if (exp_done) begin
      chk({tag, " push.tt_push"}, 32'(tt.tt_push), 1);
      chk({tag, " push.tt_pop"},  32'(tt.tt_pop), 0);
      chk({tag, " push.type"},    32'(tt.tt_type_wr), 1);
      chk({tag, " push.val"},     32'(tt.tt_val_wr), 32'(exp_val));
      chk({tag, " push.var"},     32'(tt.tt_var_wr), exp_var);
      chk({tag, " push.assign"},  32'(assign_en), 1);
      chk({tag, " push.done"},    32'(bt_done), 1);
      chk({tag, " push.unsat"},   32'(bt_unsat), 0);
      chk({tag, " push.fvar"},    32'(flip_var), exp_var);
      chk({tag, " push.fval"},    32'(flip_val), 32'(exp_val));
      if (exp_cnt < 3) exp_cnt++;
    end else begin
      chk({tag, " unsat.pulse"},  32'(bt_unsat), 1);
      chk({tag, " unsat.empty"},  32'(tt.tt_empty), 1);
      chk({tag, " unsat.tt_pop"}, 32'(tt.tt_pop), 0);
      chk({tag, " unsat.push"},   32'(tt.tt_push), 0);
      chk({tag, " unsat.done"},   32'(bt_done), 0);
    end
    @(negedge clock);
    chk({tag, " after.busy"},  32'(bt_busy), 0);
    chk({tag, " after.done"},  32'(bt_done), 0);
    chk({tag, " after.unsat"}, 32'(bt_unsat), 0);
    chk({tag, " after.fvar"},  32'(flip_var), 0);
`ifdef BT_STATS_EN
    chk({tag, " after.count"}, 32'(bt_count), exp_cnt);
`endif
    if (exp_done) begin
      chk({tag, " stack.depth"}, sp, dep - n + 1);
      chk({tag, " stack.top"},   {30'(tt.tt_var_rd), tt.tt_type_rd, tt.tt_val_rd},
                                 {30'(exp_var), 1'b1, exp_val});
    end else begin
      chk({tag, " stack.depth"}, sp, 0);
    end
  endtask

  function automatic vec_t mk(input int depth, input bit [3:0] typ, input bit [3:0] val,
                              input int v0, input int v1, input int v2, input int v3,
                              input int n_pops, input bit done, input int fvar, input bit fval);
    vec_t r;
    r.depth = depth; r.typ = typ; r.val = val;
    r.vars[0] = v0; r.vars[1] = v1; r.vars[2] = v2; r.vars[3] = v3;
    r.n_pops = n_pops; r.done = done; r.fvar = fvar; r.fval = fval;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    // entries listed bottom -> top; typ bit: 0 Decide, 1 Forced
    tbl[0] = mk(3, 4'b0110, 4'b0101, 3, 5, 7, 0, 3, 1, 3, 0);
    tbl[1] = mk(2, 4'b0001, 4'b0001, 9, 2, 0, 0, 1, 1, 2, 1);
    tbl[2] = mk(2, 4'b0011, 4'b0001, 1, 4, 0, 0, 2, 0, 0, 0);
    tbl[3] = mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(2, 4'b0000, 4'b0010, 6, 8, 0, 0, 1, 1, 8, 0);

    reset = 1; bt_start = 1; tb_clear = 1; tb_push = 0;
    tb_push_type = 0; tb_push_val = 0; tb_push_var = '0;
    exp_cnt = 0;
    repeat (3) @(negedge clock);
    chk("rst.busy",   32'(bt_busy), 0);
    chk("rst.done",   32'(bt_done), 0);
    chk("rst.unsat",  32'(bt_unsat), 0);
    chk("rst.tt_pop", 32'(tt.tt_pop), 0);
    chk("rst.push",   32'(tt.tt_push), 0);
    chk("rst.un_en",  32'(unassign_en), 0);
    chk("rst.assign", 32'(assign_en), 0);
    chk("rst.fvar",   32'({flip_var, flip_val}), 0);
    reset = 0; bt_start = 0; tb_clear = 0;
    @(negedge clock);
    chk("rst.idle_busy", 32'(bt_busy), 0);
`ifdef BT_STATS_EN
    chk("rst.count", 32'(bt_count), 0);
`endif

    for (int k = 0; k < 5; k++) begin
      clear_stack();
      for (int i = 0; i < tbl[k].depth; i++)
        push_entry(tbl[k].typ[i], tbl[k].val[i], tbl[k].vars[i]);
      exp_pops.delete();
      for (int i = 0; i < tbl[k].n_pops; i++)
        exp_pops.push_back(tbl[k].vars[tbl[k].depth - 1 - i]);
      exp_done = tbl[k].done; exp_var = tbl[k].fvar; exp_val = tbl[k].fval;
      run_bt($sformatf("vec%0d", k), 1'b0);
    end

    // bt_start held high during the backtrack must not queue a second one
    clear_stack();
    push_entry(0, 1, 3); push_entry(1, 0, 5); push_entry(1, 1, 7);
    model_bt();
    run_bt("hold_start", 1'b1);

    // reset in a POP cycle aborts: nothing popped that cycle, no push, no done
    clear_stack();
    push_entry(0, 1, 3); push_entry(1, 0, 5); push_entry(1, 1, 7);
    @(negedge clock); bt_start = 1;
    @(negedge clock); bt_start = 0;
    chk("abort.first_pop", 32'(tt.tt_pop), 1);
    @(negedge clock); reset = 1;
    #1;
    chk("abort.pop_in_rst", 32'(tt.tt_pop), 0);
    chk("abort.un_in_rst",  32'(unassign_en), 0);
    @(negedge clock); reset = 0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort.busy", 32'(bt_busy), 0);
      chk("abort.push", 32'(tt.tt_push), 0);
      chk("abort.done", 32'(bt_done), 0);
      @(negedge clock);
    end
    chk("abort.depth", sp, 2);
`ifdef BT_STATS_EN
    chk("abort.count", 32'(bt_count), 0);
`endif

    for (int it = 0; it < 40; it++) begin
      int depth;
      clear_stack();
      depth = $urandom_range(0, 6);
      for (int i = 0; i < depth; i++)
        push_entry(($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), $urandom_range(0, 63));
      model_bt();
      run_bt($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
